press_classifier: RTL and testbench

- Downstream consumer of the debounced button stage.
- Takes the debounced key level plus the shared clock-enable tick and classifies each user gesture as a short, long or double press.
- Emits one-clk event pulses that drive the LED/control logic in place of a bare press pulse.
- All timing is counted in clock-enable ticks, not raw clk cycles.

---
 rtl/press_classifier.sv | 164 ++++++++++++++++
 tb/tb_press_classifier.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Classifies user gestures on a debounced key into short, long and double
// presses. All timing is measured in clock-enable ticks (ce), so the same
// block works for any clk rate as long as the ce generator is scaled.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   ce            one-clk-wide clock-enable tick
//   btn_level     debounced key level, 1 = pressed
//   short_press   one-clk pulse: single short press recognised
//   long_press    one-clk pulse: hold reached LONG_TICKS
//   double_press  one-clk pulse: second press started within the gap window
//   busy          high while a gesture is in progress (state != IDLE)
//
// Parameters:
//   LONG_TICKS    ce ticks a press must be held to count as long (2..2^CNT_W-1)
//   GAP_TICKS     ce ticks after release in which a second press makes a
//                 double press (2..2^CNT_W-1)
//   CNT_W         tick counter width
// -----------------------------------------------------------------------------
module press_classifier #(
  parameter int LONG_TICKS = 1000,
  parameter int GAP_TICKS  = 300,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  // Elaboration-time sanity checks on the parameter ranges.
  if (LONG_TICKS < 2 || LONG_TICKS > (2 ** CNT_W) - 1) begin : g_bad_long
    $error("press_classifier: LONG_TICKS out of range");
  end
  if (GAP_TICKS < 2 || GAP_TICKS > (2 ** CNT_W) - 1) begin : g_bad_gap
    $error("press_classifier: GAP_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS1   = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             btn_prev;

  logic             press_edge;
  logic             release_lvl;
  logic             long_hit;
  logic             gap_hit;

  logic             short_nxt;
  logic             long_nxt;
  logic             double_nxt;

  // Saturating increment: the counter parks at all-ones instead of wrapping,
  // so a very long dwell can never alias back onto a threshold value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + 1'b1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Input decode (combinational, from registered btn_prev)
  // ---------------------------------------------------------------------------
  assign press_edge  = btn_level & ~btn_prev;
  assign release_lvl = ~btn_level;
  assign long_hit    = ce && (cnt == LONG_LAST);
  assign gap_hit     = ce && (cnt == GAP_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and event decision
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (press_edge) begin
          state_nxt = PRESS1;
        end
      end
      PRESS1: begin
        // Release wins over the long threshold landing on the same cycle.
        if (release_lvl) begin
          state_nxt = GAP;
        end else if (long_hit) begin
          long_nxt  = 1'b1;
          state_nxt = WAIT_REL;
        end
      end
      GAP: begin
        // A second press on the final gap tick still counts as a double.
        if (press_edge) begin
          double_nxt = 1'b1;
          state_nxt  = WAIT_REL;
        end else if (gap_hit) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_REL: begin
        if (release_lvl) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter, edge history and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      // Treat the key as already down so a key held through reset is ignored
      // until it is released and pressed again.
      btn_prev     <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      btn_prev     <= btn_level;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      busy         <= (state_nxt != IDLE);
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (ce) begin
        cnt <= sat_inc(cnt);
      end
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_press_classifier
//
// Directed scoreboard bench for press_classifier with LONG_TICKS = 4,
// GAP_TICKS = 3 and ce every 4th clk. The stimulus process pushes each
// expected event (kind and the cycle count at which it must be visible) into a
// queue; a monitor process pops and compares whenever any event pulse is seen.
// -----------------------------------------------------------------------------
module tb_press_classifier;

  localparam int K_NONE   = 0;
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;

  logic clk;
  logic rst;
  logic ce;
  logic btn_level;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t got;
  int  cyc;
  int  checks;
  int  errors;
  int  act_kind;
  int  n_pulses;

  press_classifier #(
    .LONG_TICKS(4),
    .GAP_TICKS (3),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .btn_level   (btn_level),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every visible event pulse must match the head of the queue.
  always @(negedge clk) begin
    n_pulses = int'(short_press) + int'(long_press) + int'(double_press);
    if (n_pulses > 1) begin
      chk("one_hot_events", n_pulses, 1);
    end
    if (n_pulses > 0) begin
      act_kind = long_press ? K_LONG : (double_press ? K_DOUBLE : K_SHORT);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", act_kind, K_NONE);
      end else begin
        got = exp_q.pop_front();
        chk("event_kind", act_kind, got.kind);
        chk("event_cycle", cyc, got.cyc);
      end
    end
  end

  // One clk of stimulus. An expected event is due at the next posedge.
  task automatic cyc1(input logic b, input logic c, input int exp_kind);
    ev_t e;
    btn_level = b;
    ce        = c;
    if (exp_kind != K_NONE) begin
      e.kind = exp_kind;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // One ce tick period: three idle clks then the ce clk. exp_first marks an
  // event decided on the first clk (press edge), exp_ce one decided on ce.
  task automatic tick(input logic b, input int exp_first, input int exp_ce);
    cyc1(b, 1'b0, exp_first);
    cyc1(b, 1'b0, K_NONE);
    cyc1(b, 1'b0, K_NONE);
    cyc1(b, 1'b1, exp_ce);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    ce        = 1'b0;
    btn_level = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_short", int'(short_press), 0);
    chk("reset_long", int'(long_press), 0);
    chk("reset_double", int'(double_press), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);

    // Short press: 2 ticks held, short on 3rd gap tick.
    tick(1'b1, K_NONE, K_NONE);
    chk("short_busy_pressed", int'(busy), 1);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_SHORT);
    chk("short_busy_after", int'(busy), 0);
    tick(1'b0, K_NONE, K_NONE);

    // Long press: hold 6 ticks, long on 4th, silent release.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_LONG);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    chk("long_busy_held", int'(busy), 1);
    cyc1(1'b0, 1'b0, K_NONE);
    chk("long_busy_release", int'(busy), 0);
    cyc1(1'b0, 1'b0, K_NONE);
    cyc1(1'b0, 1'b0, K_NONE);
    cyc1(1'b0, 1'b1, K_NONE);
    tick(1'b0, K_NONE, K_NONE);

    // Double press: second press one tick after release.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b1, K_DOUBLE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    chk("double_busy_after", int'(busy), 0);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);

    // Gap boundary: press edge on the 3rd gap tick is a double.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    cyc1(1'b0, 1'b0, K_NONE);
    cyc1(1'b0, 1'b0, K_NONE);
    cyc1(1'b0, 1'b0, K_NONE);
    cyc1(1'b1, 1'b1, K_DOUBLE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);

    // Gap boundary: press one tick later gives short, then a fresh short.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_SHORT);
    tick(1'b1, K_NONE, K_NONE);
    chk("gap_late_busy", int'(busy), 1);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_SHORT);
    tick(1'b0, K_NONE, K_NONE);

    // Reset mid-gesture, key held through reset release.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    rst = 1'b1;
    cyc1(1'b1, 1'b0, K_NONE);
    rst = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b1, 1'b1, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    chk("rst_held_busy", int'(busy), 0);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_SHORT);
    tick(1'b0, K_NONE, K_NONE);

    // Release coinciding with the 4th tick: no long, short after the gap.
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    tick(1'b1, K_NONE, K_NONE);
    cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b0, 1'b1, K_NONE);
    chk("rel_long_gap_busy", int'(busy), 1);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_SHORT);
    tick(1'b0, K_NONE, K_NONE);

    // ce stuck low: no timeouts, but edges still tracked.
    repeat (24) cyc1(1'b1, 1'b0, K_NONE);
    chk("ce0_busy_held", int'(busy), 1);
    repeat (24) cyc1(1'b0, 1'b0, K_NONE);
    chk("ce0_busy_gap", int'(busy), 1);
    cyc1(1'b1, 1'b0, K_DOUBLE);
    repeat (8) cyc1(1'b1, 1'b0, K_NONE);
    cyc1(1'b0, 1'b0, K_NONE);
    chk("ce0_busy_done", int'(busy), 0);
    tick(1'b0, K_NONE, K_NONE);
    tick(1'b0, K_NONE, K_NONE);

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
